// File: rtl/calc_vector_sequencer_if.sv
// Board-side bus of calc_vector_sequencer: sweep controls, calculator results,
// and the driven vector / captured log.
interface calc_vector_sequencer_if;
    logic        start;
    logic        auto;
    logic        step_btn;
    logic        y;
    logic        z;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic [3:0]  idx;
    logic [31:0] yz_log;
    logic        done;

    modport master (
        output start, auto, step_btn, y, z,
        input  a, b, c, d, idx, yz_log, done
    );

    modport slave (
        input  start, auto, step_btn, y, z,
        output a, b, c, d, idx, yz_log, done
    );
endinterface

// File: rtl/calc_vector_sequencer.sv
// Sweeps {a,b,c,d} through 0..15 and logs the calculator's {y,z} for each vector.
// Define DEBOUNCE_EN to debounce step_btn over DEBOUNCE_CYCLES stable cycles.
module calc_vector_sequencer #(
    parameter int unsigned TICK_CYCLES     = 100_000_000,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    calc_vector_sequencer_if.slave  bus
);
    localparam int unsigned CNT_MAX = (TICK_CYCLES > SETTLE_CYCLES) ? TICK_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (TICK_CYCLES < 1 || SETTLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("calc_vector_sequencer: cycle parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        WAIT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [31:0]        log_q, log_d;
    logic               done_q, done_d;

    logic [1:0]         sync_q;
    logic               step_lvl;
    logic               step_prev_q;
    logic               step_p;
    logic               wait_exit;

`ifdef DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0]    db_cnt_q;
    logic               db_lvl_q;

    // Counts consecutive cycles the synchronised level disagrees with the debounced one.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else if (sync_q[1] == db_lvl_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q <= '0;
            db_lvl_q <= sync_q[1];
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign step_lvl = db_lvl_q;
`else
    assign step_lvl = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            step_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.step_btn};
            step_prev_q <= step_lvl;
        end
    end

    assign step_p    = step_lvl & ~step_prev_q;
    assign wait_exit = bus.auto ? (cnt_q == TICK_LAST) : step_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            log_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            log_q   <= log_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
            CAPTURE: state_d = WAIT;
            WAIT:    if (wait_exit) state_d = (idx_q == 4'd15) ? DONE : SETTLE;
            DONE:    if (bus.start) state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // done is registered off DONE, so it rises one edge after the last WAIT exit.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        log_d  = log_q;
        done_d = (state_q == DONE) && !bus.start;
        unique case (state_q)
            IDLE, DONE: begin
                cnt_d = '0;
                if (bus.start) begin
                    idx_d = '0;
                    log_d = '0;
                end
            end
            SETTLE: begin
                cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
            end
            CAPTURE: begin
                cnt_d = '0;
                log_d[{idx_q, 1'b0} +: 2] = {bus.y, bus.z};
            end
            WAIT: begin
                // Manual mode parks the dwell count at 0 so a switch to auto starts fresh.
                cnt_d = bus.auto ? cnt_q + 1'b1 : '0;
                if (wait_exit) begin
                    cnt_d = '0;
                    if (idx_q != 4'd15) idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign bus.a      = idx_q[3];
    assign bus.b      = idx_q[2];
    assign bus.c      = idx_q[1];
    assign bus.d      = idx_q[0];
    assign bus.idx    = idx_q;
    assign bus.yz_log = log_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_calc_vector_sequencer.sv
// Scoreboard bench for calc_vector_sequencer with a parity/AND calculator stub.
module tb_calc_vector_sequencer;
    localparam int unsigned TICK   = 4;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned DEB    = 3;
    localparam int          PERIOD = SETTLE + 1 + TICK;
    localparam logic [31:0] FULL_LOG = 32'h6882_8228;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    calc_vector_sequencer_if bus ();

    calc_vector_sequencer #(
        .TICK_CYCLES     (TICK),
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.y = bus.a ^ bus.b ^ bus.c ^ bus.d;
    assign bus.z = bus.a & bus.b & bus.c & bus.d;

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic        done;
        logic [31:0] log;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] exp_log(input int unsigned n);
        logic [31:0] l;
        logic [3:0]  v;
        l = '0;
        for (int unsigned i = 0; i < n; i++) begin
            v = 4'(i);
            l[2*i+1] = ^v;
            l[2*i]   = &v;
        end
        return l;
    endfunction

    task automatic push(input logic [3:0] i, input logic dn, input logic [31:0] l, input int c);
        exp_t x;
        x.idx = i; x.done = dn; x.log = l; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic push_auto(input int unsigned n0, input int unsigned n1, input int c0);
        for (int unsigned n = n0; n <= n1; n++)
            push(4'(n), 1'b0, exp_log(n), c0 + PERIOD * int'(n - n0));
    endtask

    // Monitor: every change of {idx,done} is one DUT event matched against the queue.
    always @(negedge clk) begin
        if (mon_en && {bus.idx, bus.done} !== prev) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got idx=%0d done=%0b, expected no change", bus.idx, bus.done);
            end else begin
                mon_e = sb.pop_front();
                check("ev_idx", 32'(bus.idx), 32'(mon_e.idx));
                check("ev_abcd", 32'({bus.a, bus.b, bus.c, bus.d}), 32'(mon_e.idx));
                check("ev_done", 32'(bus.done), 32'(mon_e.done));
                check("ev_log", bus.yz_log, mon_e.log);
                if (mon_e.cyc >= 0) check("ev_cycle", cyc, mon_e.cyc);
            end
        end
        prev = {bus.idx, bus.done};
    end

    task automatic pulse_start(output int k);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        bus.start = 1'b0;
    endtask

    task automatic press(input int len);
        @(negedge clk);
        bus.step_btn = 1'b1;
        repeat (len) @(negedge clk);
        bus.step_btn = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_idx(input logic [3:0] target, input int budget);
        int n = 0;
        while (bus.idx !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idx", 32'(bus.idx), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abcd"}, 32'({bus.a, bus.b, bus.c, bus.d}), 32'd0);
        check({tag, "_idx"}, 32'(bus.idx), 32'd0);
        check({tag, "_log"}, bus.yz_log, 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int a;
        logic [3:0] g;

        bus.start    = 1'b0;
        bus.auto     = 1'b1;
        bus.step_btn = 1'b0;

        // Reset held for two edges, then idle with start low.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");
        repeat (10) @(negedge clk);
        check_all_zero("idle");
        mon_en = 1'b1;

        // Auto sweep: idx every PERIOD cycles, done at k+1+16*PERIOD.
        pulse_start(k);
        push_auto(1, 15, k + PERIOD);
        push(4'd15, 1'b1, FULL_LOG, k + 1 + 16 * PERIOD);
        drain(200, "auto_drain");
        check("auto_done", 32'(bus.done), 32'd1);
        check("auto_log", bus.yz_log, FULL_LOG);

        // Restart from DONE; mid-sweep start and step presses must be ignored.
        pulse_start(k);
        push(4'd0, 1'b0, 32'd0, k);
        push_auto(1, 15, k + PERIOD);
        push(4'd15, 1'b1, FULL_LOG, k + 1 + 16 * PERIOD);
        wait_idx(4'd5, 100);
        pulse_start(a);
        press(5);
        repeat (8) @(negedge clk);
        press(5);
        drain(200, "ignore_drain");
        check("ignore_log", bus.yz_log, FULL_LOG);

        // Manual sweep: three clean presses.
        @(negedge clk);
        bus.auto = 1'b0;
        pulse_start(k);
        push(4'd0, 1'b0, 32'd0, k);
        repeat (10) @(negedge clk);
        for (int s = 1; s <= 3; s++) begin
            push(4'(s), 1'b0, exp_log(s), -1);
            press(6);
            repeat (12) @(negedge clk);
            drain(5, "manual_drain");
        end
        check("manual_log8", 32'(bus.yz_log[7:0]), 32'h28);
        check("manual_idx", 32'(bus.idx), 32'd3);
        repeat (20) @(negedge clk);
        check("manual_hold", 32'(bus.idx), 32'd3);

        // auto 0->1 in WAIT: dwell restarts from 0, then reset at idx 9.
        @(negedge clk);
        bus.auto = 1'b1;
        a = cyc;
        push_auto(4, 9, a + TICK);
        wait_idx(4'd9, 100);
        @(negedge clk);
        reset = 1'b1;
        push(4'd0, 1'b0, 32'd0, -1);
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midreset");
        drain(5, "midreset_drain");

        pulse_start(k);
        push_auto(1, 15, k + PERIOD);
        push(4'd15, 1'b1, FULL_LOG, k + 1 + 16 * PERIOD);
        drain(200, "restart_drain");
        check("restart_log", bus.yz_log, FULL_LOG);

        // Step glitch then a clean 5-cycle press.
        @(negedge clk);
        bus.auto = 1'b0;
        pulse_start(k);
        push(4'd0, 1'b0, 32'd0, k);
        repeat (10) @(negedge clk);
`ifdef DEBOUNCE_EN
        g = 4'd0;
`else
        g = 4'd1;
        push(g, 1'b0, exp_log(1), -1);
`endif
        press(2);
        repeat (12) @(negedge clk);
        drain(5, "glitch_drain");
        check("glitch_idx", 32'(bus.idx), 32'(g));
        push(g + 4'd1, 1'b0, exp_log(int'(g) + 1), -1);
        press(5);
        repeat (15) @(negedge clk);
        drain(5, "press_drain");
        check("press_idx", 32'(bus.idx), 32'(g + 4'd1));

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
